// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, control FSM states, instruction classes and ALUOp codes shared by mc_ctrl and aluctr.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB
    } state_e;
    typedef enum logic [2:0] {C_MEM, C_RTYPE, C_BEQ, C_J, C_ADDI, C_ILL} instr_class_e;
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: opcode to instruction class, kept separate so a pipelined control can reuse it.
module mc_ctrl_dec
    import mips_pkg::*;
(
    input  logic [5:0]   opcode_i,
    output instr_class_e class_o
);
    always_comb
        class_o = (opcode_i == OP_LW || opcode_i == OP_SW) ? C_MEM :
                  opcode_i == OP_RTYPE ? C_RTYPE :
                  opcode_i == OP_BEQ   ? C_BEQ   :
                  opcode_i == OP_J     ? C_J     :
                  opcode_i == OP_ADDI  ? C_ADDI  : C_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS main control FSM with memory-ready stalls and combinational output decode.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [1:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_source,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);
    state_e       state_q, state_d, st;
    instr_class_e cls;

    mc_ctrl_dec u_dec (.opcode_i(opcode), .class_o(cls));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = cls == C_MEM   ? S_MEMADR :
                                cls == C_RTYPE ? S_EXEC   :
                                cls == C_BEQ   ? S_BRANCH :
                                cls == C_J     ? S_JUMP   :
                                cls == C_ADDI  ? S_ADDIEX : S_FETCH;
            S_MEMADR: state_d = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk)
        state_q <= rst_n ? state_d : S_FETCH;

    // While in reset, decode as FETCH so selects are steady; strobes are then masked.
    assign st    = rst_n ? state_q : S_FETCH;
    assign state = ST_W'(st);

    always_comb begin
        {alu_op, alu_src_a, alu_src_b, pc_source} = '0;
        {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op} = '0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = cls == C_ILL;
                instr_done = cls == C_ILL;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: {iord, mem_read} = 2'b11;
            S_MEMWB: {mem_to_reg, reg_write, instr_done} = 3'b111;
            S_MEMWR: begin
                {iord, mem_write} = 2'b11;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: {reg_dst, reg_write, instr_done} = 3'b111;
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: {reg_write, instr_done} = 2'b11;
            default: ;
        endcase
        if (!rst_n)
            {pc_en, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op} = '0;
    end
endmodule
